sparc_exu_div_seq: RTL and testbench

- Sequential 64/32 divider for SPARC V8 UDIV/SDIV, fed directly by the per-thread Y register output (yreg_mdq_y_e) and the E-stage operands.
- Forms the dividend {Y, rs1}, divides by rs2 at one quotient bit per cycle, truncates toward zero, and saturates on overflow per V8.
- Returns a 32-bit quotient plus the requesting thread's one-hot tag to the EXU writeback path.

---
 rtl/sparc_exu_div_seq.sv | 197 +++++++++++++++++++
 tb/tb_sparc_exu_div_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sparc_exu_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : sparc_exu_div_seq
// Purpose  : Sequential 64/32 restoring divider for SPARC V8 UDIV/SDIV.
//            Dividend is {Y, rs1}; one quotient bit per cycle, truncation
//            toward zero, V8 saturation on overflow, one-hot thread tag out.
//            Optional macro SPARC_EXU_DIV_CC_EN adds div_ccr = {N,Z,V,C}.
// Revision : 1.0 - initial release
// ============================================================================
module sparc_exu_div_seq #(
    parameter int DW   = 32,
    parameter int CNTW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          div_start,
    input  logic          div_signed,
    input  logic [3:0]    div_thr,
    input  logic [DW-1:0] yreg_mdq_y_e,
    input  logic [DW-1:0] div_rs1,
    input  logic [DW-1:0] div_rs2,
    input  logic          div_kill,
    output logic          div_busy,
    output logic          div_done,
    output logic [DW-1:0] div_result,
    output logic [3:0]    div_thr_done,
    output logic          div_ovf,
    output logic          div_zero
`ifdef SPARC_EXU_DIV_CC_EN
    ,
    output logic [3:0]    div_ccr
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [DW-1:0]   c_pos_max = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]   c_neg_min = {1'b1, {(DW-1){1'b0}}};
    localparam logic [CNTW-1:0] c_last    = CNTW'(DW-1);

    logic [2:0]      r_state, w_next;
    logic            r_signed, r_neg, r_ovf_pre;
    logic [3:0]      r_thr;
    logic [DW-1:0]   r_hi;       // Y, then unused after PREP
    logic [DW-1:0]   r_lo;       // rs1; shifts dividend bits out, quotient bits in
    logic [DW-1:0]   r_dvs;      // raw divisor, then its magnitude
    logic [DW:0]     r_rem;
    logic [CNTW-1:0] r_cnt;
    logic [DW-1:0]   r_result;
    logic            r_ovf, r_zero;

    logic            w_dvd_neg, w_dvs_neg, w_dvs_zero, w_ovf_pre, w_qbit;
    logic [2*DW-1:0] w_dvd, w_dvd_abs;
    logic [DW-1:0]   w_dvs_abs;
    logic [DW:0]     w_shift, w_diff;
    logic            w_res_we, w_ovf_nxt;
    logic [DW-1:0]   w_res_nxt;

    // Magnitude preparation and the restoring trial subtraction
    always_comb begin
        w_dvd      = {r_hi, r_lo};
        w_dvd_neg  = r_signed & r_hi[DW-1];
        w_dvs_neg  = r_signed & r_dvs[DW-1];
        w_dvd_abs  = w_dvd_neg ? -w_dvd : w_dvd;
        w_dvs_abs  = w_dvs_neg ? -r_dvs : r_dvs;
        w_dvs_zero = (r_dvs == '0);
        // Upper half not below divisor means the quotient exceeds DW bits
        w_ovf_pre  = (w_dvd_abs[2*DW-1:DW] >= w_dvs_abs);
        w_shift    = {r_rem[DW-1:0], r_lo[DW-1]};
        w_diff     = w_shift - {1'b0, r_dvs};
        // Remainder stays below divisor, so bit DW is a clean borrow flag
        w_qbit     = ~w_diff[DW];
    end

    // Result write-back value: zero-divide in PREP, sign fix/saturation in FIX
    always_comb begin
        w_res_we  = 1'b0;
        w_ovf_nxt = 1'b0;
        w_res_nxt = '0;
        if (r_state == S_PREP && !div_kill && w_dvs_zero) begin
            w_res_we = 1'b1;
        end else if (r_state == S_FIX && !div_kill) begin
            w_res_we = 1'b1;
            if (!r_signed) begin
                w_ovf_nxt = r_ovf_pre;
                w_res_nxt = w_ovf_nxt ? {DW{1'b1}} : r_lo;
            end else if (!r_neg) begin
                w_ovf_nxt = r_ovf_pre | r_lo[DW-1];
                w_res_nxt = w_ovf_nxt ? c_pos_max : r_lo;
            end else begin
                w_ovf_nxt = r_ovf_pre | (r_lo > c_neg_min);
                w_res_nxt = w_ovf_nxt ? c_neg_min : -r_lo;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; kill aborts only the working states
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (div_start) w_next = S_PREP;
            S_PREP: begin
                if (div_kill)        w_next = S_IDLE;
                else if (w_dvs_zero) w_next = S_DONE;
                else if (w_ovf_pre)  w_next = S_FIX;
                else                 w_next = S_ITER;
            end
            S_ITER: begin
                if (div_kill)             w_next = S_IDLE;
                else if (r_cnt == c_last) w_next = S_FIX;
            end
            S_FIX:  w_next = div_kill ? S_IDLE : S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result/flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_signed  <= 1'b0;
            r_neg     <= 1'b0;
            r_ovf_pre <= 1'b0;
            r_thr     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (div_start) begin
                    r_signed <= div_signed;
                    r_thr    <= div_thr;
                    r_hi     <= yreg_mdq_y_e;
                    r_lo     <= div_rs1;
                    r_dvs    <= div_rs2;
                    r_ovf    <= 1'b0;
                    r_zero   <= 1'b0;
                end
                S_PREP: if (!div_kill && !w_dvs_zero) begin
                    r_dvs     <= w_dvs_abs;
                    r_neg     <= w_dvd_neg ^ w_dvs_neg;
                    r_ovf_pre <= w_ovf_pre;
                    r_rem     <= {1'b0, w_dvd_abs[2*DW-1:DW]};
                    r_lo      <= w_dvd_abs[DW-1:0];
                    r_cnt     <= '0;
                end
                S_ITER: begin
                    r_rem <= w_qbit ? w_diff : w_shift;
                    r_lo  <= {r_lo[DW-2:0], w_qbit};
                    r_cnt <= r_cnt + CNTW'(1);
                end
                default: ;
            endcase
            if (w_res_we) begin
                r_result <= w_res_nxt;
                r_ovf    <= w_ovf_nxt;
                r_zero   <= (r_state == S_PREP);
            end
        end
    end

`ifdef SPARC_EXU_DIV_CC_EN
    logic [3:0] r_ccr;

    // Condition codes follow each result write and hold with it
    always_ff @(posedge clk) begin
        if (reset)         r_ccr <= '0;
        else if (w_res_we) r_ccr <= {w_res_nxt[DW-1], (w_res_nxt == '0), w_ovf_nxt, 1'b0};
    end

    assign div_ccr = r_ccr;
`endif

    assign div_busy     = (r_state != S_IDLE);
    assign div_done     = (r_state == S_DONE);
    assign div_thr_done = div_done ? r_thr : 4'b0000;
    assign div_result   = r_result;
    assign div_ovf      = r_ovf;
    assign div_zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_sparc_exu_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sparc_exu_div_seq
// Purpose  : Scoreboard bench for sparc_exu_div_seq: expected results are
//            queued at start and compared when div_done is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sparc_exu_div_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        div_start = 1'b0, div_signed = 1'b0, div_kill = 1'b0;
    logic [3:0]  div_thr = '0;
    logic [31:0] yreg_mdq_y_e = '0, div_rs1 = '0, div_rs2 = '0;
    logic        div_busy, div_done, div_ovf, div_zero;
    logic [31:0] div_result;
    logic [3:0]  div_thr_done;
`ifdef SPARC_EXU_DIV_CC_EN
    logic [3:0]  div_ccr;
`endif

    sparc_exu_div_seq #(.DW(32), .CNTW(6)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .div_thr      (div_thr),
        .yreg_mdq_y_e (yreg_mdq_y_e),
        .div_rs1      (div_rs1),
        .div_rs2      (div_rs2),
        .div_kill     (div_kill),
        .div_busy     (div_busy),
        .div_done     (div_done),
        .div_result   (div_result),
        .div_thr_done (div_thr_done),
        .div_ovf      (div_ovf),
        .div_zero     (div_zero)
`ifdef SPARC_EXU_DIV_CC_EN
        ,
        .div_ccr      (div_ccr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  thr;
        logic        ovf;
        logic        zero;
        int          lat;
        int          start;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Independent reference: full-width division on magnitudes
    function automatic exp_t model(input logic [31:0] y, a, b, input logic sgn,
                                   input logic [3:0] thr, input int start);
        exp_t        e;
        logic [63:0] ma, mb, mq;
        logic [31:0] nb, nq;
        logic        neg;
        e.thr = thr; e.ovf = 1'b0; e.zero = 1'b0; e.start = start;
        if (b == 32'd0) begin
            e.res = '0; e.zero = 1'b1; e.lat = 2;
        end else begin
            ma = {y, a}; mb = {32'd0, b}; neg = 1'b0;
            if (sgn) begin
                if (y[31]) ma = -ma;
                if (b[31]) begin nb = -b; mb = {32'd0, nb}; end
                neg = y[31] ^ b[31];
            end
            mq = ma / mb;
            e.lat = (mq[63:32] != 32'd0) ? 3 : 35;
            if (!sgn) begin
                e.ovf = (mq[63:32] != 32'd0);
                e.res = e.ovf ? 32'hFFFF_FFFF : mq[31:0];
            end else if (!neg) begin
                e.ovf = (mq > 64'h7FFF_FFFF);
                e.res = e.ovf ? 32'h7FFF_FFFF : mq[31:0];
            end else begin
                e.ovf = (mq > 64'h8000_0000);
                nq = mq[31:0];
                nq = -nq;
                e.res = e.ovf ? 32'h8000_0000 : nq;
            end
        end
        return e;
    endfunction

    // Monitor: pop and compare on every done pulse
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (div_done) begin
            if (sb.size() == 0) begin
                check_val("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_val("result",   div_result,   e.res);
                check_val("thr_done", div_thr_done, e.thr);
                check_val("ovf",      div_ovf,      e.ovf);
                check_val("zero",     div_zero,     e.zero);
                check_val("latency",  cyc - e.start, e.lat);
`ifdef SPARC_EXU_DIV_CC_EN
                check_val("ccr", div_ccr, {e.res[31], (e.res == 32'd0), e.ovf, 1'b0});
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    // Pulse start for one cycle, then scramble operands (need not stay stable)
    task automatic drive_start(input logic [31:0] y, a, b, input logic sgn,
                               input logic [3:0] thr, input bit push);
        if (push) sb.push_back(model(y, a, b, sgn, thr, cyc));
        div_start = 1'b1; div_signed = sgn; div_thr = thr;
        yreg_mdq_y_e = y; div_rs1 = a; div_rs2 = b;
        step();
        div_start = 1'b0; div_kill = 1'b0;
        yreg_mdq_y_e = $urandom; div_rs1 = $urandom; div_rs2 = $urandom;
        div_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || div_busy) && n < 100) begin
            step();
            n++;
        end
        check_val("timeout", 64'(n < 100), 64'd1);
        step();
    endtask

    task automatic run_op(input logic [31:0] y, a, b, input logic sgn, input logic [3:0] thr);
        drive_start(y, a, b, sgn, thr, 1'b1);
        wait_idle();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] y, a, b;
        repeat (3) step();
        reset = 1'b0;
        check_val("rst_busy",   div_busy,     1'b0);
        check_val("rst_done",   div_done,     1'b0);
        check_val("rst_result", div_result,   32'd0);
        check_val("rst_thr",    div_thr_done, 4'd0);
        check_val("rst_ovf",    div_ovf,      1'b0);
        check_val("rst_zero",   div_zero,     1'b0);
`ifdef SPARC_EXU_DIV_CC_EN
        check_val("rst_ccr",    div_ccr,      4'd0);
`endif
        step();

        // Directed vectors
        run_op(32'd0,         32'd100,       32'd7,         1'b0, 4'b0010);
        run_op(32'd1,         32'd0,         32'd1,         1'b0, 4'b0100);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'd7,         1'b1, 4'b1000);
        run_op(32'd0,         32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'b0001);
        run_op(32'd0,         32'h8000_0000, 32'd1,         1'b1, 4'b0010);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 32'd0,         1'b0, 4'b0100);
        run_op(32'hFFFF_FFFF, 32'h8000_0000, 32'd1,         1'b1, 4'b0001);
        run_op(32'd0,         32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'b1000);
        run_op(32'h0000_0006, 32'h0000_0000, 32'd7,         1'b0, 4'b0010);

        // Kill mid-operation, then restart two cycles later
        drive_start(32'd0, 32'd1000, 32'd3, 1'b0, 4'b0001, 1'b0);
        repeat (9) step();
        div_kill = 1'b1;
        step();
        div_kill = 1'b0;
        check_val("kill_busy", div_busy, 1'b0);
        step();
        run_op(32'd0, 32'd9, 32'd3, 1'b0, 4'b0100);

        // Start pulsed while busy is ignored
        drive_start(32'd0, 32'd50, 32'd5, 1'b0, 4'b1000, 1'b1);
        repeat (4) step();
        div_start = 1'b1; div_rs1 = 32'd77; div_rs2 = 32'd2; div_thr = 4'b0001;
        step();
        div_start = 1'b0;
        wait_idle();

        // Start in the DONE cycle is ignored
        drive_start(32'd0, 32'd64, 32'd8, 1'b0, 4'b0010, 1'b1);
        repeat (34) step();
        div_start = 1'b1; div_rs1 = 32'd5; div_rs2 = 32'd5;
        step();
        div_start = 1'b0;
        check_val("done_start_busy", div_busy, 1'b0);
        wait_idle();

        // Kill and start in the same idle cycle: start wins
        div_kill = 1'b1;
        run_op(32'd0, 32'd21, 32'd4, 1'b0, 4'b0001);

        // Reset mid-operation
        drive_start(32'd0, 32'd500, 32'd9, 1'b0, 4'b0100, 1'b0);
        repeat (19) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("midrst_busy",   div_busy,   1'b0);
        check_val("midrst_done",   div_done,   1'b0);
        check_val("midrst_result", div_result, 32'd0);
        step();
        run_op(32'd0, 32'd500, 32'd9, 1'b0, 4'b0100);

        // Random operands, sign-extended or small Y to exercise both paths
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            if (i % 3 == 0) b = -b;
            y = (i % 2 == 0) ? {32{a[31]}} : 32'($urandom_range(0, 3));
            run_op(y, a, b, 1'($urandom_range(0, 1)), 4'(1 << (i % 4)));
        end

        repeat (5) step();
        check_val("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
